// File: rtl/divider_pkg.sv
// Shared constants and pipeline stage record for the restoring divider.
// Build option: define DIVIDER_RADIX4_EN to retire two quotient bits per
// register stage (half the latency, identical results).
package divider_pkg;

  localparam int DIV_WIDTH = 32;

`ifdef DIVIDER_RADIX4_EN
  localparam int DIV_BITS_PER_STAGE = 2;
`else
  localparam int DIV_BITS_PER_STAGE = 1;
`endif

  localparam int DIV_LATENCY = DIV_WIDTH / DIV_BITS_PER_STAGE;

  // One pipeline slot. vld separates real operands from reset-cleared slots,
  // so cleared slots never turn into a 0/0 = all-ones result at the output.
  typedef struct packed {
    logic                 vld;
    logic [DIV_WIDTH-1:0] rem;  // partial remainder
    logic [DIV_WIDTH-1:0] quo;  // partial quotient, bits filled MSB first
    logic [DIV_WIDTH-1:0] div;  // divisor copy travelling with the operands
    logic [DIV_WIDTH-1:0] dvd;  // dividend copy, bit BIT consumed by each step
  } div_stage_t;

endpackage

// File: rtl/divider_stage.sv
// One combinational restoring division step, resolving quotient bit BIT.
// Invalid slots pass through untouched so flushed data stays zero.
module divider_stage
  import divider_pkg::*;
#(
  parameter int BIT = 0
) (
  input  div_stage_t st_i,
  output div_stage_t st_o
);

  logic [DIV_WIDTH:0] shifted;
  logic               ge;

  // Shift in the next dividend bit and trial-subtract the divisor.
  always_comb begin
    shifted = {st_i.rem, st_i.dvd[BIT]};
    ge      = (shifted >= {1'b0, st_i.div});
    st_o    = st_i;
    if (st_i.vld) begin
      // When ge holds, the difference is below the divisor and fits WIDTH
      // bits, so the low-order subtraction is exact.
      st_o.rem      = ge ? (shifted[DIV_WIDTH-1:0] - st_i.div) : shifted[DIV_WIDTH-1:0];
      st_o.quo[BIT] = ge;
    end
  end

endmodule

// File: rtl/divider.sv
// Fully pipelined unsigned restoring divider: quotient and remainder of
// dividend/divisor, one new operand pair per clock, fixed latency of
// DIV_LATENCY edges. Divide by zero gives all-ones quotient and
// remainder = dividend. Build option: DIVIDER_RADIX4_EN (two steps per stage).
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  // The stage record is sized from the package, so WIDTH has to follow it.
  if (WIDTH != DIV_WIDTH || WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("divider: WIDTH must be even, >= 2 and equal to divider_pkg::DIV_WIDTH");
  end

  div_stage_t stage_q [0:DIV_LATENCY];
  div_stage_t stage_d [0:DIV_LATENCY];
  div_stage_t chain   [1:DIV_LATENCY][0:DIV_BITS_PER_STAGE];

  // Stage 0 captures the raw operands with empty remainder and quotient.
  always_comb begin
    stage_d[0]     = '0;
    stage_d[0].vld = 1'b1;
    stage_d[0].div = divisor;
    stage_d[0].dvd = dividend;
  end

  // Register stage s resolves quotient bits WIDTH-k for its k values.
  for (genvar s = 1; s <= DIV_LATENCY; s++) begin : g_stage
    assign chain[s][0] = stage_q[s-1];
    for (genvar j = 0; j < DIV_BITS_PER_STAGE; j++) begin : g_step
      divider_stage #(
        .BIT(WIDTH - 1 - ((s - 1) * DIV_BITS_PER_STAGE + j))
      ) u_step (
        .st_i(chain[s][j]),
        .st_o(chain[s][j+1])
      );
    end
    assign stage_d[s] = chain[s][DIV_BITS_PER_STAGE];
  end

  // Pipeline registers; synchronous reset flushes every slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s <= DIV_LATENCY; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s <= DIV_LATENCY; s++) begin
        stage_q[s] <= stage_d[s];
      end
    end
  end

  assign quotient  = stage_q[DIV_LATENCY].quo;
  assign remainder = stage_q[DIV_LATENCY].rem;

endmodule

// File: tb/tb_divider.sv
// Directed and random checks for the pipelined divider.
module tb_divider;
  import divider_pkg::*;

  localparam int LAT = DIV_LATENCY;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] va [0:9];
  logic [31:0] vb [0:9];
  logic [31:0] eq [0:9];
  logic [31:0] er [0:9];

  logic [31:0] qa [$];
  logic [31:0] qb [$];

  divider u_dut (
    .clk(clk),
    .rst(rst),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Releases reset and streams table entries first..first+n-1, one per clock.
  // The pipeline must have been flushed on the previous edge.
  task automatic play(input int first, input int n);
    for (int i = 0; i < n + LAT; i++) begin
      rst = 1'b0;
      if (i < n) begin
        dividend = va[first+i];
        divisor  = vb[first+i];
      end else begin
        dividend = 32'd77;
        divisor  = 32'd7;
      end
      @(negedge clk);
      if (i < LAT) begin
        chk("pre_q", quotient, 0);
        chk("pre_r", remainder, 0);
      end else begin
        chk($sformatf("q[%0d]", first + i - LAT), quotient,  eq[first+i-LAT]);
        chk($sformatf("r[%0d]", first + i - LAT), remainder, er[first+i-LAT]);
      end
    end
  endtask

  // Every cycle: push the current pair, then check the pair LAT edges old.
  task automatic rand_cycle(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ea;
    logic [31:0] eb;
    dividend = a;
    divisor  = b;
    qa.push_back(a);
    qb.push_back(b);
    @(negedge clk);
    if (qa.size() == LAT + 1) begin
      ea = qa.pop_front();
      eb = qb.pop_front();
      if (eb != 0) begin
        chk("rnd_sum", {32'd0, quotient} * {32'd0, eb} + {32'd0, remainder}, {32'd0, ea});
        chk("rnd_rlt", {63'd0, remainder < eb}, 64'd1);
      end else begin
        chk("rnd_dz_q", quotient, 32'hFFFF_FFFF);
        chk("rnd_dz_r", remainder, ea);
      end
    end
  endtask

  initial begin
    logic [31:0] ha;
    logic [31:0] hb;

    va[0] = 32'd100;        vb[0] = 32'd7;        eq[0] = 32'd14;         er[0] = 32'd2;
    va[1] = 32'd3;          vb[1] = 32'd10;       eq[1] = 32'd0;          er[1] = 32'd3;
    va[2] = 32'hFFFF_FFFF;  vb[2] = 32'd1;        eq[2] = 32'hFFFF_FFFF;  er[2] = 32'd0;
    va[3] = 32'd5;          vb[3] = 32'd0;        eq[3] = 32'hFFFF_FFFF;  er[3] = 32'd5;
    va[4] = 32'd0;          vb[4] = 32'd0;        eq[4] = 32'hFFFF_FFFF;  er[4] = 32'd0;
    va[5] = 32'd1000;       vb[5] = 32'd3;        eq[5] = 32'd333;        er[5] = 32'd1;
    va[6] = 32'd1000;       vb[6] = 32'd7;        eq[6] = 32'd142;        er[6] = 32'd6;
    va[7] = 32'h8000_0000;  vb[7] = 32'h0001_0000; eq[7] = 32'h0000_8000; er[7] = 32'd0;
    va[8] = 32'h1234_5678;  vb[8] = 32'd4096;     eq[8] = 32'h0001_2345;  er[8] = 32'h678;
    va[9] = 32'd65535;      vb[9] = 32'd256;      eq[9] = 32'd255;        er[9] = 32'd255;

    // Reset held for three edges with changing inputs.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dividend = $urandom;
      divisor  = $urandom;
      @(negedge clk);
      chk("rst_q", quotient, 0);
      chk("rst_r", remainder, 0);
    end

    // Latency, corner cases and back-to-back throughput.
    play(0, 8);

    // Reset for one edge while ten operations are in flight.
    for (int i = 0; i < 10; i++) begin
      dividend = 32'd2000 + i;
      divisor  = 32'd3;
      @(negedge clk);
    end
    rst = 1'b1;
    dividend = 32'd999;
    divisor  = 32'd4;
    @(negedge clk);
    chk("flush_q", quotient, 0);
    chk("flush_r", remainder, 0);
    play(8, 2);

    // Random pairs held for 50 clocks each.
    for (int p = 0; p < 100; p++) begin
      ha = $urandom;
      hb = $urandom & 32'h0000_FFFF;
      for (int c = 0; c < 50; c++) rand_cycle(ha, hb);
    end

    // Random pairs changing every clock.
    for (int p = 0; p < 5000; p++) begin
      rand_cycle($urandom, $urandom & 32'h0000_FFFF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Fully pipelined unsigned integer divider using a restoring algorithm.
- Produces quotient and remainder of dividend/divisor at a fixed latency.
- Accepts a new operand pair every clock; no handshake.
- Serves as the DIV/DIVU/REM/REMU datapath core of the RISC-V execute stage. Sign handling lives outside this block.

Parameters:
- WIDTH, 32, operand and result width in bits; must be ≥2 and even.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- dividend  input  WIDTH  unsigned dividend
- divisor  input  WIDTH  unsigned divisor
- quotient  output  WIDTH  unsigned quotient, registered
- remainder  output  WIDTH  unsigned remainder, registered

Behaviour:
- One clock; reset is synchronous and active-high. All state changes happen on rising clk only.
- Reset: while rst=1 at a rising edge, every pipeline register (operands, partial remainders, partial quotients) clears to 0. quotient and remainder read 0 from the edge after reset is sampled.
  - Results of operands sampled before or during reset are discarded.
  - After reset deasserts, outputs stay 0 until the first post-reset operand pair reaches the output.
  - 0/0 yields q=all-ones, so a post-reset 0 output is distinguishable only by timing.
- Sampling: dividend and divisor are captured into stage 0 on every rising edge. Inputs are not required to be held stable.
- Stages: stage k (k=1..WIDTH) performs one restoring step.
  - Shift the partial remainder left by 1 and bring in dividend bit WIDTH-k (MSB first).
  - Trial-subtract the divisor using WIDTH+1-bit arithmetic.
  - If the result is non-negative, keep the difference and set quotient bit WIDTH-k to 1; otherwise keep the shifted value and set the bit to 0.
  - Each stage carries its own copy of the divisor and remaining dividend bits.
- Latency: operands sampled at edge N appear on quotient/remainder immediately after edge N+WIDTH (N+32 at default).
  - Throughput is 1 result per clock.
  - Outputs hold their value while inputs are constant.
- Results: quotient = floor(dividend/divisor); remainder = dividend - quotient*divisor; remainder < divisor when divisor≠0.
- Divide by zero: quotient = all ones (2^WIDTH-1), remainder = dividend. This falls out of the restoring algorithm and matches RISC-V DIVU/REMU. No exception flag.
- dividend < divisor: quotient 0, remainder = dividend.
- Overflow cannot occur for unsigned operands.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: DIVIDER_RADIX4_EN.
- Defined: each pipeline stage retires two quotient bits (two chained restoring steps per register). Latency becomes WIDTH/2 edges (16 at default). Results are identical.
- Undefined: one bit per stage, latency WIDTH.
- Divide-by-zero and reset behaviour are the same in both builds.

Decomposition:
- Package divider_pkg:
  - DIV_WIDTH default constant (32).
  - DIV_BITS_PER_STAGE (1 or 2, selected by the macro).
  - DIV_LATENCY = DIV_WIDTH/DIV_BITS_PER_STAGE.
  - Stage-state struct typedef: partial remainder, partial quotient, divisor, remaining dividend bits.
- Sub-module divider_stage: combinational single restoring step, instantiated once or twice per register stage via generate. Top level holds only registers and the generate loop.

Test Plan:
- rst=1 for 3 edges with random inputs → q=0, r=0 held; after release, first valid result appears exactly DIV_LATENCY edges after its sampling edge.
- 100/7 → q=14, r=2. 3/10 → q=0, r=3. 0xFFFFFFFF/1 → q=0xFFFFFFFF, r=0. All at latency 32, or 16 with DIVIDER_RADIX4_EN.
- 5/0 → q=0xFFFFFFFF, r=5. 0/0 → q=0xFFFFFFFF, r=0.
- Back-to-back, one pair per clock: 1000/3, 1000/7, 0x80000000/0x10000 → consecutive outputs (333,1), (142,6), (0x8000,0) on successive edges.
- Reset asserted for one edge while 10 operations are in flight → all flushed; outputs 0; next result is the first pair sampled after reset.
- 10k random pairs, dividend 32-bit random and divisor random & 0x0000FFFF, changed every 50 clocks plus every-cycle bursts → q*divisor+r == dividend and r<divisor whenever divisor≠0.
